// File: rtl/psr_ctl_pkg.sv
// Shared CPU constants for the processor-status controller: flag bit positions,
// flag-opcode and branch-condition encodings, reset value and the P load rule.
package psr_ctl_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [2:0] FOP_NONE = 3'd0;
  localparam logic [2:0] FOP_CLC  = 3'd1;
  localparam logic [2:0] FOP_SEC  = 3'd2;
  localparam logic [2:0] FOP_CLI  = 3'd3;
  localparam logic [2:0] FOP_SEI  = 3'd4;
  localparam logic [2:0] FOP_CLV  = 3'd5;
  localparam logic [2:0] FOP_CLD  = 3'd6;
  localparam logic [2:0] FOP_SED  = 3'd7;

  localparam logic [2:0] BR_BPL = 3'd0;
  localparam logic [2:0] BR_BMI = 3'd1;
  localparam logic [2:0] BR_BVC = 3'd2;
  localparam logic [2:0] BR_BVS = 3'd3;
  localparam logic [2:0] BR_BCC = 3'd4;
  localparam logic [2:0] BR_BCS = 3'd5;
  localparam logic [2:0] BR_BNE = 3'd6;
  localparam logic [2:0] BR_BEQ = 3'd7;

  localparam logic [7:0] RESET_P_DEF = 8'h24;

  // B is never stored and the unused bit always reads 1.
  function automatic logic [7:0] p_fix(input logic [7:0] v);
    return {v[7:6], 1'b1, 1'b0, v[3:0]};
  endfunction

endpackage

// File: rtl/psr_ctl_if.sv
// Sequencer/ALU side bundle of the P-register controller.
interface psr_ctl_if;
  logic       ce;
  logic       alu_we;
  logic [7:0] af;
  logic [2:0] flag_op;
  logic       plp_we;
  logic [7:0] db_in;
  logic       php_brk;
  logic       int_ack;
  logic       int_nmi;
  logic [2:0] br_cond;
  logic       irq_n;
  logic       nmi_n;
  logic       so_n;
  logic [7:0] p_out;
  logic [7:0] push_byte;
  logic       br_taken;
  logic       irq_req;
  logic       nmi_req;

  modport master (
    output ce, alu_we, af, flag_op, plp_we, db_in, php_brk, int_ack, int_nmi,
           br_cond, irq_n, nmi_n, so_n,
    input  p_out, push_byte, br_taken, irq_req, nmi_req
  );

  modport slave (
    input  ce, alu_we, af, flag_op, plp_we, db_in, php_brk, int_ack, int_nmi,
           br_cond, irq_n, nmi_n, so_n,
    output p_out, push_byte, br_taken, irq_req, nmi_req
  );
endinterface

// File: rtl/psr_ctl_sync_edge.sv
// Pin synchronizer with a falling-edge pulse taken from registered samples only.
module psr_ctl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin_n_i,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Idle-high reset so a pin held low through reset does not produce an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_o = edge_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/psr_ctl.sv
// 6502 processor-status register: flag loads, branch evaluation, and the
// synchronized IRQ/NMI/SO request path for the sequencer.
module psr_ctl
  import psr_ctl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_P     = RESET_P_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  psr_ctl_if.slave   bus
);

  logic [7:0]             p_q, p_d;
  logic                   irq_req_q, irq_req_d;
  logic                   i_prev_q, i_prev_d;
  logic                   nmi_pend_q, nmi_pend_d;
  logic                   so_pend_q, so_pend_d;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   nmi_fall;
  logic                   so_fall;
  logic                   branch_flag;

  psr_ctl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .pin_n_i (bus.nmi_n),
    .fall_o  (nmi_fall)
  );

  psr_ctl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_so_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .pin_n_i (bus.so_n),
    .fall_o  (so_fall)
  );

  always_comb begin
    p_d        = p_q;
    irq_req_d  = irq_req_q;
    i_prev_d   = i_prev_q;
    so_pend_d  = so_pend_q | so_fall;
    nmi_pend_d = nmi_pend_q;
    if (bus.ce) begin
      if (bus.plp_we) begin
        p_d = p_fix(bus.db_in);
      end else if (bus.alu_we) begin
        p_d = p_fix(bus.af);
      end else begin
        case (bus.flag_op)
          FOP_CLC: p_d[FLAG_C] = 1'b0;
          FOP_SEC: p_d[FLAG_C] = 1'b1;
          FOP_CLI: p_d[FLAG_I] = 1'b0;
          FOP_SEI: p_d[FLAG_I] = 1'b1;
          FOP_CLV: p_d[FLAG_V] = 1'b0;
          FOP_CLD: p_d[FLAG_D] = 1'b0;
          FOP_SED: p_d[FLAG_D] = 1'b1;
          default: ;
        endcase
      end
      if (bus.int_ack) p_d[FLAG_I] = 1'b1;
      if (so_fall || so_pend_q) p_d[FLAG_V] = 1'b1;
      so_pend_d = 1'b0;
      // I is sampled before this edge's update, giving the one-instruction CLI/SEI lag.
      irq_req_d = ~irq_sync_q[SYNC_STAGES-1] & ~i_prev_q;
      i_prev_d  = p_q[FLAG_I];
    end
    if (nmi_fall) begin
      nmi_pend_d = 1'b1;
    end else if (bus.ce && bus.int_ack && bus.int_nmi) begin
      nmi_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q        <= p_fix(RESET_P);
      irq_req_q  <= 1'b0;
      i_prev_q   <= 1'b1;
      nmi_pend_q <= 1'b0;
      so_pend_q  <= 1'b0;
      irq_sync_q <= '1;
    end else begin
      p_q        <= p_d;
      irq_req_q  <= irq_req_d;
      i_prev_q   <= i_prev_d;
      nmi_pend_q <= nmi_pend_d;
      so_pend_q  <= so_pend_d;
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
    end
  end

  always_comb begin
    case (bus.br_cond[2:1])
      2'd0:    branch_flag = p_q[FLAG_N];
      2'd1:    branch_flag = p_q[FLAG_V];
      2'd2:    branch_flag = p_q[FLAG_C];
      default: branch_flag = p_q[FLAG_Z];
    endcase
  end

  assign bus.br_taken  = (branch_flag == bus.br_cond[0]);
  assign bus.p_out     = p_q;
  assign bus.push_byte = {p_q[7:6], 1'b1, bus.php_brk, p_q[3:0]};
  assign bus.irq_req   = irq_req_q;
  assign bus.nmi_req   = nmi_pend_q;

endmodule

// File: doc/psr_ctl.md
Name: psr_ctl

Overview:
- Processor-status (P) register and interrupt-request controller for the 6502-compatible core.
- It is the consumer side of the ALU flag path. It latches the ALU flag output (AF) into P, feeds P back to the ALU carry/flag input, and applies flag opcodes, PLP and PHP.
- It also evaluates branch conditions and produces synchronized, I-masked IRQ and edge-detected NMI/SO requests for the sequencer.

Parameters:
- SYNC_STAGES, 2, flops in each irq_n/nmi_n/so_n synchronizer (minimum 2).
- RESET_P, 8'h24, P value after reset (I=1, bit5=1).

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  CPU cycle enable; P, irq_req and I-sampling update only when ce=1.
- alu_we  in  1  load P from af.
- af  in  8  ALU flag result, NV1BDIZC.
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- plp_we  in  1  load P from db_in (PLP/RTI).
- db_in  in  8  data bus byte for PLP.
- php_brk  in  1  B bit value for the pushed byte (1 for PHP/BRK, 0 for IRQ/NMI).
- int_ack  in  1  sequencer entering interrupt; sets I.
- int_nmi  in  1  qualifies int_ack: 1 means NMI serviced.
- br_cond  in  3  opcode[7:5] of the branch opcode.
- irq_n, nmi_n, so_n  in  1 each  asynchronous pins.
- p_out  out  8  current P (bit5=1, bit4=0), drives ALU P input.
- push_byte  out  8  {P[7:6],1,php_brk,P[3:0]}.
- br_taken  out  1  branch condition true.
- irq_req  out  1  registered masked IRQ request.
- nmi_req  out  1  NMI pending.

Behaviour:
- Reset (async, reset_n=0):
  - P=RESET_P with bit4 forced 0.
  - irq_req=0, nmi_req=0, I_prev=1.
  - Synchronizers are set to 1 (pins idle high); the NMI and SO edge registers are set to 1.
- P storage:
  - Bit5 always reads 1; bit4 is never stored and reads 0 on p_out.
- P update priority on a ce cycle:
  1. plp_we: P <= db_in.
  2. Else alu_we: P <= af.
  3. Else flag_op: the selected bit is set or cleared; other bits are held.
  - In every load, bit5 is forced 1 and bit4 forced 0.
  - int_ack then forces I=1, overriding any lower-priority I result in the same cycle.
  - so falling edge then forces V=1, overriding all other V writes in the same cycle.
- Write visibility: a write is visible on p_out the cycle after the ce edge. There is no combinational bypass.
- push_byte and br_taken are combinational from the registered P.
- br_taken mapping by br_cond:
  - 0: N=0; 1: N=1
  - 2: V=0; 3: V=1
  - 4: C=0; 5: C=1
  - 6: Z=0; 7: Z=1
- Synchronizers: irq_n, nmi_n and so_n each pass through SYNC_STAGES flops clocked every clock, independent of ce.
- NMI handling:
  - An nmi falling edge is detected on the synchronized signal every clock.
  - The edge sets nmi_pend (nmi_req = nmi_pend).
  - ce & int_ack & int_nmi clears nmi_pend. A new edge in the same clock wins, and nmi_pend stays 1.
  - A held-low nmi_n produces exactly one request.
  - An edge arriving while ce=0 is held until serviced.
- SO handling: an so falling edge latches so_pend, which is applied to V at the next ce cycle and then cleared.
- IRQ handling:
  - irq_req is level-sensitive and not latched.
  - On each ce edge: irq_req <= ~irq_sync & ~I_prev; I_prev <= P.I (the value before this edge's update).
  - Consequence: CLI or SEI takes effect on irq_req one ce cycle late, matching 6502 CLI/SEI latency.
  - Example: CLI at ce cycle k; irq_req first goes high after edge k+2 when irq_n is held low.
  - PLP/RTI follow the same path.
- The block does not arbitrate NMI vs IRQ; the sequencer prioritizes nmi_req.
- Reset mid-operation: all pending state is lost, and P returns to RESET_P.

Decomposition:
- Shared cpu package holds:
  - Flag bit index constants: C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7.
  - FLAG_OP encodings, br_cond encodings, and RESET_P.
- One sub-module: sync_edge. It contains the SYNC_STAGES synchronizer plus a registered falling-edge pulse, and is instantiated for nmi_n and so_n. irq_n uses its synchronizer output only.

Test Plan:
- Reset, then release reset_n → p_out=8'h24, irq_req=0, nmi_req=0. Then alu_we with af=8'hFF → p_out=8'hEF.
- plp_we (db_in=8'h00) and alu_we (af=8'h81) in the same ce cycle → p_out=8'h20. Then SEC+SED → 8'h29. Push with php_brk=1 → push_byte=8'h39.
- Hold irq_n=0 with I=1, issue CLI at ce cycle k → irq_req=0 through edge k+1 and 1 after edge k+2. SEI then drops irq_req one ce cycle late.
- Pulse nmi_n low for 3 clocks with ce=0 throughout → nmi_req=1 after SYNC_STAGES+1 clocks and held. int_ack+int_nmi on ce → nmi_req=0 and p_out I=1. Held-low nmi_n gives no second request.
- For each br_cond 0..7 with P=8'h20 and then P=8'hE3 → br_taken is 1,0,1,0,1,0,1,0 and then 0,1,0,1,0,1,0,1.
- so_n falling edge in the same ce cycle as CLV → V=1. Assert reset_n=0 mid-sequence with nmi pending → nmi_req=0 and P=8'h24 immediately, asynchronously.
